gpio_evt: RTL

GPIO input-event block: the input-direction companion to the pad output mux. It takes raw pad inputs, synchronises and debounces them, and detects rising and falling edges. Detected edges are latched into sticky per-pad status bits that drive one level interrupt to the processor. Software accesses it through an APB responder on the peripheral bus, alongside the existing GPIO regblock.

---
 rtl/gpio_evt_pkg.sv | 38 +++
 rtl/gpio_evt_filter.sv | 44 ++++
 rtl/gpio_evt.sv | 109 ++++++++++
 3 files changed

// File: rtl/gpio_evt_pkg.sv
// Shared definitions for the GPIO input-event block: register offsets,
// reset constants and the APB offset decoder.
package gpio_evt_pkg;

    localparam int unsigned APB_AW = 16;
    localparam int unsigned APB_DW = 32;

    localparam logic [APB_AW-1:0] ADDR_LEVEL    = 16'h0000;
    localparam logic [APB_AW-1:0] ADDR_RISE_EN  = 16'h0004;
    localparam logic [APB_AW-1:0] ADDR_FALL_EN  = 16'h0008;
    localparam logic [APB_AW-1:0] ADDR_STATUS   = 16'h000C;
    localparam logic [APB_AW-1:0] ADDR_DEBOUNCE = 16'h0010;

    localparam logic [APB_DW-1:0] RST_REG = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_LEVEL,
        SEL_RISE_EN,
        SEL_FALL_EN,
        SEL_STATUS,
        SEL_DEBOUNCE,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [APB_AW-1:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_LEVEL:    sel = SEL_LEVEL;
            ADDR_RISE_EN:  sel = SEL_RISE_EN;
            ADDR_FALL_EN:  sel = SEL_FALL_EN;
            ADDR_STATUS:   sel = SEL_STATUS;
            ADDR_DEBOUNCE: sel = SEL_DEBOUNCE;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_evt_filter.sv
// Per-pad synchroniser and tick-sampled debouncer; flags a rise or fall on
// the tick where the stable level changes.
module gpio_evt_filter (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_pad,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_s0;
    logic r_stable;
    logic w_settled;

    // New level confirmed when two consecutive tick samples agree
    assign w_settled = i_tick & (r_s0 == r_sync) & (r_s0 != r_stable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_s0     <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
            if (i_tick) begin
                r_s0 <= r_sync;
                if (w_settled) begin
                    r_stable <= r_s0;
                end
            end
        end
    end

    assign o_level  = r_stable;
    assign o_rise_c = w_settled & r_s0;
    assign o_fall_c = w_settled & ~r_s0;

endmodule

// File: rtl/gpio_evt.sv
// GPIO input-event block: debounce prescaler, APB register file, sticky
// edge status and the level interrupt.
module gpio_evt
    import gpio_evt_pkg::*;
#(
    parameter int unsigned N_PADS     = 23,
    parameter int unsigned W_DEBOUNCE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  apbs_psel,
    input  logic                  apbs_penable,
    input  logic                  apbs_pwrite,
    input  logic [APB_AW-1:0]     apbs_paddr,
    input  logic [APB_DW-1:0]     apbs_pwdata,
    output logic [APB_DW-1:0]     apbs_prdata,
    output logic                  apbs_pready,
    output logic                  apbs_pslverr,
    input  logic [N_PADS-1:0]     padin,
    output logic [N_PADS-1:0]     level,
    output logic                  irq
);

    logic [W_DEBOUNCE-1:0] r_debounce;
    logic [W_DEBOUNCE-1:0] r_cnt;
    logic [N_PADS-1:0]     r_rise_en;
    logic [N_PADS-1:0]     r_fall_en;
    logic [N_PADS-1:0]     r_status;

    logic                  w_tick;
    logic                  w_access;
    logic                  w_write;
    reg_sel_e              w_sel;
    logic [N_PADS-1:0]     w_level;
    logic [N_PADS-1:0]     w_rise;
    logic [N_PADS-1:0]     w_fall;
    logic [N_PADS-1:0]     w_set;
    logic [N_PADS-1:0]     w_clr;
    logic                  w_unused;

    assign w_access = apbs_psel & apbs_penable;
    assign w_write  = w_access & apbs_pwrite;
    assign w_sel    = decode_addr(apbs_paddr);
    assign w_tick   = (r_cnt == r_debounce);
    assign w_unused = ^apbs_pwdata;

    for (genvar g = 0; g < N_PADS; g++) begin : g_pad
        gpio_evt_filter u_filter (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_pad    (padin[g]),
            .o_level  (w_level[g]),
            .o_rise_c (w_rise[g]),
            .o_fall_c (w_fall[g])
        );
    end

    // Hardware set takes priority over a same-cycle software clear
    assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr = (w_write && (w_sel == SEL_STATUS)) ? apbs_pwdata[N_PADS-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_debounce <= W_DEBOUNCE'(RST_REG);
            r_cnt      <= W_DEBOUNCE'(RST_REG);
            r_rise_en  <= N_PADS'(RST_REG);
            r_fall_en  <= N_PADS'(RST_REG);
            r_status   <= N_PADS'(RST_REG);
        end else begin
            if (w_write && (w_sel == SEL_DEBOUNCE)) begin
                r_debounce <= apbs_pwdata[W_DEBOUNCE-1:0];
                r_cnt      <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W_DEBOUNCE'(1);
            end
            if (w_write && (w_sel == SEL_RISE_EN)) begin
                r_rise_en <= apbs_pwdata[N_PADS-1:0];
            end
            if (w_write && (w_sel == SEL_FALL_EN)) begin
                r_fall_en <= apbs_pwdata[N_PADS-1:0];
            end
            r_status <= (r_status & ~w_clr) | w_set;
        end
    end

    // Read data is only driven during the access phase
    always_comb begin
        apbs_prdata = '0;
        if (w_access) begin
            case (w_sel)
                SEL_LEVEL:    apbs_prdata = APB_DW'(w_level);
                SEL_RISE_EN:  apbs_prdata = APB_DW'(r_rise_en);
                SEL_FALL_EN:  apbs_prdata = APB_DW'(r_fall_en);
                SEL_STATUS:   apbs_prdata = APB_DW'(r_status);
                SEL_DEBOUNCE: apbs_prdata = APB_DW'(r_debounce);
                default:      apbs_prdata = '0;
            endcase
        end
    end

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = w_access & (w_sel == SEL_NONE);
    assign level        = w_level;
    assign irq          = |r_status;

endmodule
